data_sram_responder: RTL and testbench

//  Slave end of the core's data_sram interface (en/wen/addr/wdata -> rdata).

---
 rtl/data_sram_responder_pkg.sv | 31 +++
 rtl/data_sram_responder_if.sv | 19 +
 rtl/data_sram_responder_sram_byte_ram.sv | 25 ++
 rtl/data_sram_responder.sv | 111 +++++++++++
 tb/tb_data_sram_responder.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_sram_responder_pkg.sv
// rtl/data_sram_responder_pkg.sv - region bases, config offsets and shared helpers for data_sram_responder
package data_sram_responder_pkg;

    localparam logic [31:0] DEF_RAM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DEF_CONF_BASE = 32'hBFAF_0000;

    localparam logic [15:0] OFF_LED     = 16'h0000;
    localparam logic [15:0] OFF_SWITCH  = 16'h0004;
    localparam logic [15:0] OFF_TIMER   = 16'h0008;
    localparam logic [15:0] OFF_TMRCMP  = 16'h000C;
    localparam logic [15:0] OFF_IRQSTAT = 16'h0010;

    // Region of the last read; steers the registered read-data mux.
    typedef enum logic [1:0] {
        RGN_NONE = 2'd0,
        RGN_RAM  = 2'd1,
        RGN_CONF = 2'd2
    } region_e;

    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wen);
        logic [31:0] r;
        r = cur;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) r[8*i +: 8] = wdata[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// rtl/data_sram_responder_if.sv - data_sram request/response bundle between core and responder
interface data_sram_responder_if;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        bus_err;

    modport master (
        output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        input  data_sram_rdata, bus_err
    );

    modport slave (
        input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
        output data_sram_rdata, bus_err
    );
endinterface

// File: rtl/data_sram_responder_sram_byte_ram.sv
// rtl/data_sram_responder_sram_byte_ram.sv - synchronous byte-writable word RAM with registered read
module sram_byte_ram #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wen,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:2**AW-1];

    // Read output only moves on a read so the top can hold rdata between reads.
    always_ff @(posedge clk) begin
        if (en) begin
            if (wen == 4'b0000) rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data_sram slave: address decode, local RAM, LED/switch/timer registers
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int          RAM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = DEF_RAM_BASE,
    parameter logic [31:0] CONF_BASE = DEF_CONF_BASE
) (
    input  logic                   clk,
    input  logic                   rst,
    data_sram_responder_if.slave   bus,
    output logic [15:0]            led,
    input  logic [7:0]             switch,
    output logic                   timer_irq
);

    localparam logic [32:0] RAM_SPAN = 33'd4 << RAM_AW;

    logic [31:0] ram_off;
    logic        ram_hit, conf_hit, is_rd, is_wr;
    logic [13:0] word_off;
    logic        sel_led, sel_switch, sel_timer, sel_cmp, sel_irq;
    logic [31:0] conf_rdata, ram_q, conf_q, rdata;
    logic [31:0] timer, timer_cmp;
    logic [7:0]  sw_meta, sw_sync;
    logic        irq_status, irq_clear, bus_err_q;
    region_e     tag;

    assign ram_off  = bus.data_sram_addr - RAM_BASE;
    assign ram_hit  = {1'b0, ram_off} < RAM_SPAN;
    assign conf_hit = !ram_hit && (bus.data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign is_rd    = bus.data_sram_en && (bus.data_sram_wen == 4'b0000);
    assign is_wr    = bus.data_sram_en && (bus.data_sram_wen != 4'b0000);
    assign word_off = bus.data_sram_addr[15:2];

    assign sel_led    = conf_hit && (word_off == OFF_LED[15:2]);
    assign sel_switch = conf_hit && (word_off == OFF_SWITCH[15:2]);
    assign sel_timer  = conf_hit && (word_off == OFF_TIMER[15:2]);
    assign sel_cmp    = conf_hit && (word_off == OFF_TMRCMP[15:2]);
    assign sel_irq    = conf_hit && (word_off == OFF_IRQSTAT[15:2]);
    assign irq_clear  = is_wr && sel_irq && bus.data_sram_wen[0] && bus.data_sram_wdata[0];

    sram_byte_ram #(.AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (bus.data_sram_en && ram_hit),
        .wen   (bus.data_sram_wen),
        .addr  (ram_off[RAM_AW+1:2]),
        .wdata (bus.data_sram_wdata),
        .rdata (ram_q)
    );

    always_comb begin
        conf_rdata = 32'h0;
        if (sel_led)         conf_rdata = {16'h0, led};
        else if (sel_switch) conf_rdata = {24'h0, sw_sync};
        else if (sel_timer)  conf_rdata = timer;
        else if (sel_cmp)    conf_rdata = timer_cmp;
        else if (sel_irq)    conf_rdata = {31'h0, irq_status};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led        <= 16'h0;
            timer      <= 32'h0;
            timer_cmp  <= 32'hFFFF_FFFF;
            irq_status <= 1'b0;
            sw_meta    <= 8'h0;
            sw_sync    <= 8'h0;
            tag        <= RGN_NONE;
            conf_q     <= 32'h0;
            bus_err_q  <= 1'b0;
        end else begin
            sw_meta   <= switch;
            sw_sync   <= sw_meta;
            bus_err_q <= bus.data_sram_en && !ram_hit && !conf_hit;

            if (is_wr && sel_led) begin
                if (bus.data_sram_wen[0]) led[7:0]  <= bus.data_sram_wdata[7:0];
                if (bus.data_sram_wen[1]) led[15:8] <= bus.data_sram_wdata[15:8];
            end

            // A TIMER write replaces the increment for that cycle.
            if (is_wr && sel_timer) timer <= merge_bytes(timer, bus.data_sram_wdata, bus.data_sram_wen);
            else                    timer <= timer + 32'd1;

            if (is_wr && sel_cmp) timer_cmp <= merge_bytes(timer_cmp, bus.data_sram_wdata, bus.data_sram_wen);

            // Set has priority over a write-1-clear landing in the match cycle.
            irq_status <= (timer == timer_cmp) || (irq_status && !irq_clear);

            if (is_rd) begin
                tag <= ram_hit ? RGN_RAM : (conf_hit ? RGN_CONF : RGN_NONE);
                if (conf_hit) conf_q <= conf_rdata;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (tag)
            RGN_RAM:  rdata = ram_q;
            RGN_CONF: rdata = conf_q;
            default:  rdata = 32'h0;
        endcase
    end

    assign bus.data_sram_rdata = rdata;
    assign bus.bus_err         = bus_err_q;
    assign timer_irq           = irq_status;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - self-checking bench for data_sram_responder
module tb_data_sram_responder;

    localparam logic [31:0] CONF = 32'hBFAF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] led;
    logic [7:0]  switch;
    logic        timer_irq;

    data_sram_responder_if bus();

    data_sram_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .switch    (switch),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem_m [0:63];
    logic [15:0] led_m;
    logic [31:0] b2b_w [0:2];

    task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        bus.data_sram_en    = en;
        bus.data_sram_wen   = wen;
        bus.data_sram_addr  = addr;
        bus.data_sram_wdata = wdata;
    endtask

    task automatic idle;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] wen);
        logic [31:0] mask;
        mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        switch = 8'h0;
        idle();
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        drive(1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        #3 rst = 1'b0;
        @(posedge clk);
        #1 idle();
        n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 00000000", bus.data_sram_rdata); end
        n_checks++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_bus_err got %b want 0", bus.bus_err); end
        n_checks++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got %h want 0000", led); end
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b want 0", timer_irq); end
        @(posedge clk);
        #1 rst = 1'b1;
        n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL release_rdata got %h want 00000000", bus.data_sram_rdata); end
        drive(1'b1, 4'h0, CONF + 32'h8, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'd0) begin n_fail++; $display("FAIL timer_first got %h want 00000000", bus.data_sram_rdata); end
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'd1) begin n_fail++; $display("FAIL timer_second got %h want 00000001", bus.data_sram_rdata); end
        drive(1'b1, 4'h0, CONF + 32'hC, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_tmrcmp got %h want ffffffff", bus.data_sram_rdata); end
        idle();
    endtask

    task automatic test_ram_bytes;
        drive(1'b1, 4'hF, 32'h10, 32'h1122_3344);
        tick();
        drive(1'b1, 4'h1, 32'h10, 32'h0000_00AA);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL write_holds_rdata got %h want ffffffff", bus.data_sram_rdata); end
        drive(1'b1, 4'h0, 32'h10, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h1122_33AA) begin n_fail++; $display("FAIL ram_byte_merge got %h want 112233aa", bus.data_sram_rdata); end
        drive(1'b1, 4'h8, 32'h11, 32'h5500_0000);
        tick();
        drive(1'b1, 4'h0, 32'h13, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h5522_33AA) begin n_fail++; $display("FAIL ram_read_after_write got %h want 552233aa", bus.data_sram_rdata); end
        idle();
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 3; i++) begin
            b2b_w[i] = $urandom;
            drive(1'b1, 4'hF, 32'(i * 4), b2b_w[i]);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'h0, 32'(i * 4), 32'h0);
            tick();
            n_checks++; if (bus.data_sram_rdata !== b2b_w[i]) begin n_fail++; $display("FAIL b2b_read%0d got %h want %h", i, bus.data_sram_rdata, b2b_w[i]); end
        end
        idle();
    endtask

    task automatic test_switch_led;
        switch = 8'h5A;
        tick();
        tick();
        drive(1'b1, 4'h0, CONF + 32'h4, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h0000_005A) begin n_fail++; $display("FAIL switch_read got %h want 0000005a", bus.data_sram_rdata); end
        switch = 8'hA5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_checks++;
            if (bus.data_sram_rdata !== ((k < 3) ? 32'h5A : 32'hA5)) begin
                n_fail++; $display("FAIL switch_sync_edge%0d got %h want %h", k, bus.data_sram_rdata, (k < 3) ? 32'h5A : 32'hA5);
            end
        end
        drive(1'b1, 4'h3, CONF, 32'hFFFF_BEEF);
        tick();
        n_checks++; if (led !== 16'hBEEF) begin n_fail++; $display("FAIL led_write got %h want beef", led); end
        drive(1'b1, 4'h2, CONF, 32'h0000_12FF);
        tick();
        led_m = 16'h12EF;
        n_checks++; if (led !== led_m) begin n_fail++; $display("FAIL led_lane1 got %h want %h", led, led_m); end
        drive(1'b1, 4'h0, CONF, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== {16'h0, led_m}) begin n_fail++; $display("FAIL led_read got %h want %h", bus.data_sram_rdata, {16'h0, led_m}); end
        idle();
    endtask

    task automatic test_unmapped;
        drive(1'b1, 4'h0, 32'h8000_0000, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_rdata got %h want 00000000", bus.data_sram_rdata); end
        n_checks++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_err got %b want 1", bus.bus_err); end
        idle();
        tick();
        n_checks++; if (bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width got %b want 0", bus.bus_err); end
        drive(1'b1, 4'hF, 32'h8000_0000, 32'h1234_5678);
        tick();
        n_checks++; if (bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL unmapped_wr_err got %b want 1", bus.bus_err); end
        n_checks++; if (led !== led_m) begin n_fail++; $display("FAIL unmapped_wr_led got %h want %h", led, led_m); end
        drive(1'b1, 4'h0, 32'h0, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== b2b_w[0]) begin n_fail++; $display("FAIL unmapped_wr_ram got %h want %h", bus.data_sram_rdata, b2b_w[0]); end
        drive(1'b1, 4'h0, CONF + 32'h20, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h0 || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL conf_hole got rdata %h err %b want 00000000 0", bus.data_sram_rdata, bus.bus_err); end
        drive(1'b1, 4'hF, 32'h3FFC, 32'hCAFE_F00D);
        tick();
        drive(1'b1, 4'h0, 32'h3FFC, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'hCAFE_F00D || bus.bus_err !== 1'b0) begin n_fail++; $display("FAIL ram_top_word got %h err %b want cafef00d 0", bus.data_sram_rdata, bus.bus_err); end
        drive(1'b1, 4'h0, 32'h4000, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h0 || bus.bus_err !== 1'b1) begin n_fail++; $display("FAIL ram_past_end got %h err %b want 00000000 1", bus.data_sram_rdata, bus.bus_err); end
        idle();
    endtask

    task automatic test_timer;
        drive(1'b1, 4'hF, CONF + 32'h8, 32'h0000_1000);
        tick();
        drive(1'b1, 4'hF, CONF + 32'hC, 32'd20);
        tick();
        drive(1'b1, 4'hF, CONF + 32'h8, 32'd10);
        tick();
        for (int k = 1; k <= 11; k++) begin
            if (k <= 2) drive(1'b1, 4'h0, CONF + 32'h8, 32'h0);
            else idle();
            tick();
            if (k <= 2) begin
                n_checks++; if (bus.data_sram_rdata !== 32'(9 + k)) begin n_fail++; $display("FAIL timer_read_k%0d got %h want %h", k, bus.data_sram_rdata, 32'(9 + k)); end
            end
            if (k == 1 || k == 10 || k == 11) begin
                n_checks++; if (timer_irq !== (k == 11)) begin n_fail++; $display("FAIL irq_rise_k%0d got %b want %b", k, timer_irq, k == 11); end
            end
        end
        drive(1'b1, 4'h0, CONF + 32'h10, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h1) begin n_fail++; $display("FAIL irqstat_read got %h want 00000001", bus.data_sram_rdata); end
        drive(1'b1, 4'h1, CONF + 32'h10, 32'hFFFF_FFFF);
        tick();
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b want 0", timer_irq); end
        drive(1'b1, 4'hF, CONF + 32'hC, 32'd40);
        tick();
        drive(1'b1, 4'hF, CONF + 32'h8, 32'd38);
        tick();
        idle();
        tick();
        tick();
        drive(1'b1, 4'h1, CONF + 32'h10, 32'h1);
        tick();
        n_checks++; if (timer_irq !== 1'b1) begin n_fail++; $display("FAIL set_beats_clear got %b want 1", timer_irq); end
        tick();
        n_checks++; if (timer_irq !== 1'b0) begin n_fail++; $display("FAIL clear_after_match got %b want 0", timer_irq); end
        drive(1'b1, 4'hF, CONF + 32'h8, 32'hFFFF_FFFF);
        tick();
        drive(1'b1, 4'h0, CONF + 32'h8, 32'h0);
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL timer_max got %h want ffffffff", bus.data_sram_rdata); end
        tick();
        n_checks++; if (bus.data_sram_rdata !== 32'h0) begin n_fail++; $display("FAIL timer_wrap got %h want 00000000", bus.data_sram_rdata); end
        idle();
    endtask

    task automatic test_random;
        logic [31:0] exp_rd, a, d, tmp;
        logic [3:0]  w;
        logic        exp_err;
        int          kind, idx;
        for (int i = 0; i < 64; i++) begin
            mem_m[i] = $urandom;
            drive(1'b1, 4'hF, 32'(i * 4), mem_m[i]);
            tick();
        end
        exp_rd = 32'h0;
        for (int i = 0; i < 400; i++) begin
            kind    = int'($urandom_range(0, 9));
            d       = $urandom;
            w       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            exp_err = 1'b0;
            if (kind <= 5) begin
                idx = int'($urandom_range(0, 63));
                a   = 32'(idx * 4) | $urandom_range(0, 3);
                if (w == 4'h0) exp_rd = mem_m[idx];
                else mem_m[idx] = lane_merge(mem_m[idx], d, w);
            end else if (kind <= 7) begin
                a = CONF | $urandom_range(0, 3);
                if (w == 4'h0) exp_rd = {16'h0, led_m};
                else begin
                    tmp   = lane_merge({16'h0, led_m}, d, w);
                    led_m = tmp[15:0];
                end
            end else if (kind == 8) begin
                a       = 32'h8000_0000 + ($urandom_range(0, 255) << 2);
                exp_err = 1'b1;
                if (w == 4'h0) exp_rd = 32'h0;
            end else begin
                a = CONF + 32'h100 + ($urandom_range(0, 63) << 2);
                if (w == 4'h0) exp_rd = 32'h0;
            end
            drive(1'b1, w, a, d);
            tick();
            n_checks++; if (bus.data_sram_rdata !== exp_rd) begin n_fail++; $display("FAIL rand%0d_rdata addr %h wen %h got %h want %h", i, a, w, bus.data_sram_rdata, exp_rd); end
            n_checks++; if (bus.bus_err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err addr %h got %b want %b", i, a, bus.bus_err, exp_err); end
            n_checks++; if (led !== led_m) begin n_fail++; $display("FAIL rand%0d_led got %h want %h", i, led, led_m); end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired, simulation did not complete");
        $fatal(1);
    end

    initial begin
        led_m = 16'h0;
        test_reset();
        test_ram_bytes();
        test_back_to_back();
        test_switch_led();
        test_unmapped();
        test_timer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
